ps2_host_tx: RTL and testbench

// - Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.
// - Runs on clock32, beside the existing PS/2 receiver. Drives ps2_clk/ps2_data open-drain through top-level tristates.
// - busy lets the top gate the receiver, which ignores frames while busy=1.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 43 ++++
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, default timing and common commands.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int unsigned INHIBIT_CYCLES_DEF = 3200;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 480000;
    localparam int unsigned FILTER_LEN_DEF     = 4;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Odd parity over the data byte plus the parity bit itself.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 line, accepts a level after FILTER_LEN equal samples,
// and strobes fall for one cycle when the accepted level goes 1 -> 0.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic                  sync1;
    logic                  sync2;
    logic [FILTER_LEN-2:0] hist;
    logic [FILTER_LEN-1:0] window;

    always_comb begin
        window = {hist, sync2};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            hist  <= window[FILTER_LEN-2:0];
            fall  <= 1'b0;
            if (window == '0 && level) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end else if (window == '1) begin
                level <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit clocked frame
// from the device, ack check, with a watchdog between device clock edges.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [8:0]       shift;
    logic [3:0]       bitcnt;
    logic [CNT_W-1:0] cnt;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_data_i),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shift      <= {odd_parity(tx_data), tx_data};
                        bitcnt     <= '0;
                        cnt        <= '0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (clk_fall) begin
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~shift[0];
                            shift       <= {1'b0, shift[8:1]};
                        end
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        if (!data_level) begin
                            state <= WAIT_IDLE;
                        end else begin
                            error    <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clk_level && data_level) begin
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog for the device-clocked states; placed last so an abort overrides done.
            if (state inside {SEND, ACK, WAIT_IDLE}) begin
                if (clk_fall) begin
                    cnt <= '0;
                end else if (cnt == TO_LAST) begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    done        <= 1'b0;
                    error       <= 1'b1;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model receives frames, checked against
// a byte/parity reference computed from the command sent.
module tb_ps2_host_tx;

    localparam int INH = 64;
    localparam int TO  = 3000;
    localparam int FL  = 4;
    localparam int HP  = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       clk_oe;
    logic       data_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic       bfm_clk  = 1'b1;
    logic       bfm_data = 1'b1;
    logic       ps2_clk;
    logic       ps2_data;

    assign ps2_clk  = bfm_clk & ~clk_oe;
    assign ps2_data = bfm_data & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0, fall_cyc = 0;
    int clk_run = 0, last_clk_run = 0, ovl_run = 0, last_ovl = 0;
    int clk_oe_rises = 0, oe_cycles = 0;
    logic [1:0] err_oe = 2'b11;
    logic ready_after_err = 1'b0;
    bit   want_ready = 1'b0;
    logic prev_clk_oe = 1'b0;

    logic [10:0] rx_bits;
    bit          rx_ok;

    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (error) begin
            err_cnt++;
            err_cyc    = cyc;
            err_oe     = {clk_oe, data_oe};
            want_ready = 1'b1;
        end else if (want_ready) begin
            ready_after_err = tx_ready;
            want_ready      = 1'b0;
        end
        if (done && error) both_cnt++;
        if (clk_oe) clk_run++;
        else if (clk_run != 0) begin last_clk_run = clk_run; clk_run = 0; end
        if (clk_oe && data_oe) ovl_run++;
        else if (ovl_run != 0) begin last_ovl = ovl_run; ovl_run = 0; end
        if (clk_oe && !prev_clk_oe) clk_oe_rises++;
        if (clk_oe || data_oe) oe_cycles++;
        prev_clk_oe = clk_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic request(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for request-to-send, clock out 11 falls, sample each bit
    // late in the high phase, optionally ack. stop_fall>0 freezes clk low after that fall.
    task automatic device_rx(input bit ack, input int stop_fall, output logic [10:0] bits, output bit ok);
        int n;
        bits = '1;
        ok   = 1'b0;
        n = 0;
        while (ps2_clk !== 1'b0 && n < 4 * INH) begin @(negedge clk); n++; end
        n = 0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 8 * INH) begin @(negedge clk); n++; end
        if (n >= 8 * INH) return;
        for (int k = 1; k <= 11; k++) begin
            repeat (HP / 2) @(negedge clk);
            bits[k-1] = ps2_data;
            if (k == 11 && ack) bfm_data = 1'b0;
            repeat (HP / 2) @(negedge clk);
            bfm_clk  = 1'b0;
            fall_cyc = cyc;
            if (k == stop_fall) begin ok = 1'b1; return; end
            repeat (HP) @(negedge clk);
            bfm_clk = 1'b1;
        end
        repeat (HP) @(negedge clk);
        bfm_data = 1'b1;
        ok = 1'b1;
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, input string tag);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        request(d);
        device_rx(ack, 0, rx_bits, rx_ok);
        wait_outcome(d0, e0);
        chk({tag, "_frame"}, rx_ok, 1);
        chk({tag, "_inhibit_len"}, last_clk_run, INH + 1);
        chk({tag, "_req_overlap"}, last_ovl, 1);
        chk({tag, "_start"}, rx_bits[0], 0);
        chk({tag, "_byte"}, rx_bits[8:1], d);
        chk({tag, "_parity"}, rx_bits[9], model_parity(d));
        chk({tag, "_stop"}, rx_bits[10], 1);
        if (ack) begin
            chk({tag, "_done"}, done_cnt - d0, 1);
            chk({tag, "_no_error"}, err_cnt - e0, 0);
        end else begin
            chk({tag, "_error"}, err_cnt - e0, 1);
            chk({tag, "_no_done"}, done_cnt - d0, 0);
            chk({tag, "_oe_released"}, err_oe, 0);
            chk({tag, "_ready_after"}, ready_after_err, 1);
        end
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int d0, e0, r0, o0, n, delta;
        logic [7:0] r;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Device-initiated activity while idle must not move the host.
        o0 = oe_cycles;
        bfm_data = 1'b0;
        repeat (3) begin
            repeat (HP) @(negedge clk);
            bfm_clk = 1'b0;
            repeat (HP) @(negedge clk);
            bfm_clk = 1'b1;
        end
        bfm_data = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_frame_oe", oe_cycles - o0, 0);
        chk("idle_frame_busy", busy, 0);

        xfer(8'hED, 1'b1, "ed");
        xfer(8'hF4, 1'b1, "f4");
        xfer(8'h00, 1'b1, "zero");
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(0, 255));
            xfer(r, 1'b1, "rand");
        end
        r = 8'($urandom_range(0, 255));
        xfer(r, 1'b0, "noack");

        // Device stops clocking after fall 4.
        r  = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        e0 = err_cnt;
        request(r);
        device_rx(1'b1, 4, rx_bits, rx_ok);
        chk("to_frame", rx_ok, 1);
        chk("to_low_bits", rx_bits[3:1], r[2:0]);
        n = 0;
        while (err_cnt == e0 && n < TO + 100) begin @(negedge clk); n++; end
        delta = err_cyc - fall_cyc;
        chk("to_window", (delta >= TO + FL && delta <= TO + FL + 6), 1);
        chk("to_error", err_cnt - e0, 1);
        chk("to_no_done", done_cnt - d0, 0);
        chk("to_oe_released", err_oe, 0);
        @(negedge clk);
        chk("to_busy", busy, 0);
        chk("to_ready", tx_ready, 1);
        bfm_clk = 1'b1;
        repeat (30) @(negedge clk);

        // Reset in the middle of SEND, right after fall 5 drives bit 4 (0 for 0xED).
        request(8'hED);
        device_rx(1'b1, 5, rx_bits, rx_ok);
        repeat (15) @(negedge clk);
        chk("rst_mid_data_driven", data_oe, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_clk_oe", clk_oe, 0);
        chk("rst_mid_data_oe", data_oe, 0);
        chk("rst_mid_busy", busy, 0);
        bfm_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_no_error", err_cnt - e0, 0);
        xfer(8'hF4, 1'b1, "after_rst");

        // A second request while busy is dropped.
        d0 = done_cnt;
        r0 = clk_oe_rises;
        request(8'hED);
        fork
            device_rx(1'b1, 0, rx_bits, rx_ok);
            begin
                repeat (300) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                repeat (40) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_outcome(d0, err_cnt);
        repeat (3 * INH) @(negedge clk);
        chk("busy_byte", rx_bits[8:1], 8'hED);
        chk("busy_single_done", done_cnt - d0, 1);
        chk("busy_no_new_inhibit", clk_oe_rises - r0, 1);

        chk("done_error_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
